// File: rtl/upconverter.sv
// upconverter
// Digital upconverter that mixes complex baseband up to a real IF sample:
// out = I*cos(phi) - Q*sin(phi). The NCO phase steps by 'freq' once per
// accepted sample. An optional first-order error feedback shapes the noise
// caused by truncating the accumulator to a PSZ-bit phase.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   in_i/in_q  signed baseband sample (DSZ bits)
//   in_valid   sample strobe, no backpressure
//   freq       unsigned tuning word, phase step per accepted sample
//   ns_en      enables noise shaping of the phase truncation
//   out        signed real output sample, holds while out_valid is low
//   out_valid  one pulse per accepted input, four register stages later
module upconverter #(
   parameter int DSZ = 16,
   parameter int FSZ = 26,
   parameter int PSZ = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic signed [DSZ-1:0] in_i,
   input  logic signed [DSZ-1:0] in_q,
   input  logic                  in_valid,
   input  logic [FSZ-1:0]        freq,
   input  logic                  ns_en,
   output logic signed [DSZ-1:0] out,
   output logic                  out_valid
);

   localparam int RSZ = FSZ - PSZ;

   // pi in Q60, used only while building the quarter-wave table
   localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

   // round(32767*sin(2*pi*k/4096)) for k in 0..1024, evaluated at elaboration
   // with a Q60 Taylor series; wide intermediates keep the error far below
   // the rounding threshold so every entry matches the ideal table.
   function automatic logic signed [15:0] sine_entry(input int k);
      logic signed [127:0] x;
      logic signed [127:0] x2;
      logic signed [127:0] term;
      logic signed [127:0] sum;
      logic signed [127:0] scaled;
      x   = (128'(k) * PI_Q60) >>> 11;
      x2  = (x * x) >>> 60;
      term = x;
      sum  = x;
      for (int n = 1; n <= 12; n++) begin
         term = -(((term * x2) >>> 60) / 128'(4 * n * n + 2 * n));
         sum  = sum + term;
      end
      scaled = (sum * 128'sd32767 + (128'sd1 <<< 59)) >>> 60;
      return scaled[15:0];
   endfunction

   logic signed [15:0] lut [0:1024];

   for (genvar k = 0; k <= 1024; k++) begin : g_lut
      localparam logic signed [15:0] ENTRY = sine_entry(k);
      assign lut[k] = ENTRY;
   end

   logic [FSZ-1:0]        acc;
   logic [RSZ-1:0]        res;
   logic [FSZ-1:0]        ns;
   logic signed [DSZ-1:0] i_s0, q_s0, i_s1, q_s1;
   logic [PSZ-1:0]        phi_s0;
   logic [PSZ-1:0]        phi_cos;
   logic [10:0]           sin_idx, cos_idx;
   logic signed [15:0]    sin_val, cos_val;
   logic signed [15:0]    sin_s1, cos_s1;
   logic signed [31:0]    p_ic, p_qs;
   logic signed [32:0]    diff, rounded;
   logic signed [DSZ-1:0] sat;
   logic                  v0, v1, v2;

   // Shaped phase: the previous truncation residue is fed back as a signed
   // correction so the long-term average phase tracks the full accumulator.
   always_comb begin
      ns = acc + (ns_en ? {{PSZ{res[RSZ-1]}}, res} : '0);
   end

   // Stage 0: capture the sample and its phase; the NCO only moves on
   // accepted samples, while data registers simply load every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         res    <= '0;
         v0     <= 1'b0;
         i_s0   <= '0;
         q_s0   <= '0;
         phi_s0 <= '0;
      end else begin
         v0     <= in_valid;
         i_s0   <= in_i;
         q_s0   <= in_q;
         phi_s0 <= ns[FSZ-1 -: PSZ];
         if (in_valid) begin
            acc <= acc + freq;
            res <= ns[RSZ-1:0];
         end
      end
   end

   // Quarter-wave folding: bit 10 mirrors the index, bit 11 negates the value.
   // Cosine is the sine a quarter turn ahead.
   always_comb begin
      phi_cos = phi_s0 + PSZ'(1024);
      sin_idx = phi_s0[10]  ? 11'd1024 - {1'b0, phi_s0[9:0]}  : {1'b0, phi_s0[9:0]};
      cos_idx = phi_cos[10] ? 11'd1024 - {1'b0, phi_cos[9:0]} : {1'b0, phi_cos[9:0]};
      sin_val = phi_s0[11]  ? -lut[sin_idx] : lut[sin_idx];
      cos_val = phi_cos[11] ? -lut[cos_idx] : lut[cos_idx];
   end

   // Stage 1: register the sine/cosine pair with the matching I/Q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1     <= 1'b0;
         sin_s1 <= '0;
         cos_s1 <= '0;
         i_s1   <= '0;
         q_s1   <= '0;
      end else begin
         v1     <= v0;
         sin_s1 <= sin_val;
         cos_s1 <= cos_val;
         i_s1   <= i_s0;
         q_s1   <= q_s0;
      end
   end

   // Stage 2: full-precision products.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v2   <= 1'b0;
         p_ic <= '0;
         p_qs <= '0;
      end else begin
         v2   <= v1;
         p_ic <= 32'(i_s1) * 32'(cos_s1);
         p_qs <= 32'(q_s1) * 32'(sin_s1);
      end
   end

   // Exact 33-bit difference, round half up by adding half an LSB before the
   // arithmetic shift, then clamp to the output range.
   always_comb begin
      diff    = {p_ic[31], p_ic} - {p_qs[31], p_qs};
      rounded = (diff + 33'sd16384) >>> 15;
      if (rounded > 33'sd32767) begin
         sat = 16'sh7FFF;
      end else if (rounded < -33'sd32768) begin
         sat = 16'sh8000;
      end else begin
         sat = rounded[DSZ-1:0];
      end
   end

   // Stage 3: the output register only loads for valid samples so it holds
   // the last result across gaps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out       <= '0;
      end else begin
         out_valid <= v2;
         if (v2) begin
            out <= sat;
         end
      end
   end

endmodule

// File: tb/tb_upconverter.sv
// tb_upconverter
// Directed bench for the upconverter: DC carrier, quarter-rate carrier on I
// and on Q, gapped input, saturation and rounding, asynchronous reset with
// samples in flight, and noise-shaped phase against a software NCO model.
module tb_upconverter;

   localparam real PI = 3.14159265358979323846;

   logic               clk;
   logic               reset;
   logic signed [15:0] in_i;
   logic signed [15:0] in_q;
   logic               in_valid;
   logic [25:0]        freq;
   logic               ns_en;
   logic signed [15:0] out;
   logic               out_valid;

   typedef struct {
      int                 due;
      logic signed [15:0] val;
   } exp_t;

   exp_t               expQ[$];
   int                 edgeNo = 0;
   int                 assertCount = 0;
   int                 failCount = 0;
   logic signed [15:0] lastOut = 16'sd0;
   string              testName = "reset";

   upconverter dut (
      .clk       (clk),
      .reset     (reset),
      .in_i      (in_i),
      .in_q      (in_q),
      .in_valid  (in_valid),
      .freq      (freq),
      .ns_en     (ns_en),
      .out       (out),
      .out_valid (out_valid)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to place each expected output at its due edge
   always @(posedge clk) begin
      edgeNo <= edgeNo + 1;
   end

   // One comparison point: counts the assertion and reports any mismatch
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s/%s: observed %0d expected %0d", testName, tag,
                $signed(observed), $signed(expected));
      end
   endtask

   // After each edge: out_valid must match the scoreboard, and out must be
   // the due value or else hold its previous value
   task automatic checkCycle();
      bit due;
      due = (expQ.size() > 0) && (expQ[0].due == edgeNo);
      checkOutput("out_valid", {15'd0, out_valid}, {15'd0, due});
      if (due) begin
         checkOutput("out", out, expQ[0].val);
         lastOut = expQ[0].val;
         void'(expQ.pop_front());
      end else begin
         checkOutput("out_hold", out, lastOut);
      end
   endtask

   // Drive one cycle (called at posedge+1); a valid sample is due three
   // edges after the edge that accepts it
   task automatic applyStimulus(input logic v, input int i, input int q, input int expVal);
      in_valid = v;
      in_i     = 16'(i);
      in_q     = 16'(q);
      if (v) expQ.push_back('{edgeNo + 4, 16'(expVal)});
      @(posedge clk);
      #1;
      checkCycle();
   endtask

   // Reset pulse of about one cycle, raised and dropped mid-cycle
   task automatic pulseReset();
      #2;
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      checkOutput("rst_out", out, 16'd0);
      checkOutput("rst_valid", {15'd0, out_valid}, 16'd0);
      @(posedge clk);
      #1;
      checkOutput("rst_out_held", out, 16'd0);
      checkOutput("rst_valid_held", {15'd0, out_valid}, 16'd0);
      #3;
      reset = 1'b0;
      expQ.delete();
      lastOut = 16'sd0;
      @(posedge clk);
      #1;
      checkCycle();
   endtask

   // Idle until everything in flight has come out, then confirm it did
   task automatic drain();
      for (int n = 0; n < 6; n++) applyStimulus(1'b0, 0, 0, 0);
      checkOutput("drained", 16'(expQ.size()), 16'd0);
   endtask

   // Reference sine table from real arithmetic
   function automatic int lutRef(input int k);
      return int'(32767.0 * $sin(2.0 * PI * real'(k) / 4096.0));
   endfunction

   function automatic int sinRef(input int phi);
      int a;
      a = phi % 1024;
      case (phi / 1024)
         0:       return lutRef(a);
         1:       return lutRef(1024 - a);
         2:       return -lutRef(a);
         default: return -lutRef(1024 - a);
      endcase
   endfunction

   function automatic logic signed [15:0] outRef(input int i, input int q, input int phi);
      longint s;
      longint r;
      s = longint'(i) * longint'(sinRef((phi + 1024) % 4096)) - longint'(q) * longint'(sinRef(phi));
      r = (s + 64'sd16384) >>> 15;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      return 16'(r);
   endfunction

   // Back-to-back stream at freq=5 checked against the acc/res recurrence,
   // or against a fixed value when useFixed is set
   task automatic runNoise(input logic en, input int i, input int q, input int count,
                           input logic useFixed, input int fixedExp);
      logic [25:0] accM;
      logic [13:0] resM;
      logic [25:0] nsM;
      int          expVal;
      accM  = 26'd0;
      resM  = 14'd0;
      freq  = 26'd5;
      ns_en = en;
      for (int n = 0; n < count; n++) begin
         nsM    = accM + (en ? {{12{resM[13]}}, resM} : 26'd0);
         expVal = useFixed ? fixedExp : int'(outRef(i, q, int'(nsM[25:14])));
         applyStimulus(1'b1, i, q, expVal);
         accM = accM + 26'd5;
         resM = nsM[13:0];
      end
      drain();
   endtask

   initial begin
      int quarterI[4];
      int quarterQ[4];
      int satExp[6];
      quarterI = '{1000, 0, -1000, 0};
      quarterQ = '{0, -1000, 0, 1000};
      // phases 0, 2560, 1024, 3584, 2048, 512
      satExp   = '{-32767, 32767, -32766, -1, 32767, -32768};

      reset    = 1'b1;
      in_valid = 1'b0;
      in_i     = '0;
      in_q     = '0;
      freq     = '0;
      ns_en    = 1'b0;
      @(posedge clk);
      #1;
      pulseReset();

      testName = "dc";
      for (int n = 0; n < 8; n++) applyStimulus(1'b1, 1000, 0, 1000);
      drain();

      testName = "quarter_i";
      pulseReset();
      freq = 26'd16777216;
      for (int n = 0; n < 8; n++) applyStimulus(1'b1, 1000, 0, quarterI[n % 4]);
      drain();

      testName = "quarter_q";
      pulseReset();
      for (int n = 0; n < 8; n++) applyStimulus(1'b1, 0, 1000, quarterQ[n % 4]);
      drain();

      testName = "gapped";
      pulseReset();
      for (int n = 0; n < 8; n++) begin
         applyStimulus(1'b1, 1000, 0, quarterI[n % 4]);
         applyStimulus(1'b0, 0, 0, 0);
         applyStimulus(1'b0, 0, 0, 0);
      end
      drain();

      testName = "saturate";
      pulseReset();
      freq = 26'd41943040;
      for (int n = 0; n < 6; n++) applyStimulus(1'b1, -32768, 32767, satExp[n]);
      drain();

      // three samples in flight when reset hits; the phase would be 3072
      // (output 0) had the accumulator survived
      testName = "mid_reset";
      pulseReset();
      freq = 26'd16777216;
      for (int n = 0; n < 3; n++) applyStimulus(1'b1, 1000, 0, quarterI[n]);
      pulseReset();
      for (int n = 0; n < 4; n++) applyStimulus(1'b0, 0, 0, 0);
      applyStimulus(1'b1, 1000, 0, 1000);
      drain();

      testName = "ns_on_i";
      pulseReset();
      runNoise(1'b1, 32767, 0, 10000, 1'b0, 0);

      testName = "ns_on_q";
      pulseReset();
      runNoise(1'b1, 0, 32767, 2000, 1'b0, 0);

      testName = "ns_off_i";
      pulseReset();
      runNoise(1'b0, 32767, 0, 10000, 1'b1, 32766);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
